ysyx_mem_arb: RTL and testbench
===============================

YSYX_MEM_ARB -- requirements
Module: ysyx_mem_arb

Interface
REQ-001 Parameter BIT_W, default `YSYX_W_WIDTH (32), data/address width.
REQ-002 Parameter TIMEOUT, default 255, max cycles a granted transaction may stay outstanding (range 2..1023).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ifu_arvalid_i  input  1  IFU read request, held until completion.
REQ-006 ifu_araddr_i  input  BIT_W  IFU read address.
REQ-007 ifu_rvalid_o  output  1  IFU completion pulse.
REQ-008 ifu_rdata_o  output  BIT_W  IFU read data, valid with ifu_rvalid_o.
REQ-009 ifu_err_o  output  1  IFU completion was a timeout.
REQ-010 lsu_avalid_i  input  1  LSU request, held until completion.
REQ-011 lsu_wen_i  input  1  1 = write, 0 = read.
REQ-012 lsu_addr_i  input  BIT_W  LSU address.
REQ-013 lsu_wdata_i  input  BIT_W  LSU write data.
REQ-014 lsu_wstrb_i  input  BIT_W/8  LSU byte strobes.
REQ-015 lsu_rvalid_o  output  1  LSU read completion pulse.
REQ-016 lsu_rdata_o  output  BIT_W  LSU read data.
REQ-017 lsu_wready_o  output  1  LSU write completion pulse.
REQ-018 lsu_err_o  output  1  LSU completion was a timeout.
REQ-019 bus_req_o  output  1  downstream request.
REQ-020 bus_we_o / bus_addr_o / bus_wdata_o / bus_wstrb_o  output  1/BIT_W/BIT_W/BIT_W/8  registered request fields.
REQ-021 bus_gnt_i  input  1  downstream accepts request while bus_req_o=1.
REQ-022 bus_rvalid_i / bus_rdata_i  input  1/BIT_W  read response.
REQ-023 bus_bvalid_i  input  1  write response.

Function
REQ-024 FSM states IDLE, REQ, RESP; owner register (IFU/LSU); last_owner register.
REQ-025 IDLE: if exactly one requester valid, grant it; if both, grant the one not equal to last_owner; none -> stay IDLE.
REQ-026 On grant: latch address, we (IFU: 0), wdata, wstrb (IFU: 0) into bus_* registers, set owner and last_owner, clear timeout counter, go REQ next cycle (1-cycle arbitration latency).
REQ-027 REQ: bus_req_o=1; bus_* fields stable; bus_gnt_i=1 -> RESP next cycle.
REQ-028 RESP: bus_req_o=0; read completes on bus_rvalid_i, write on bus_bvalid_i; then IDLE next cycle.
REQ-029 bus_gnt_i and matching response in same REQ cycle: completion taken that cycle, go IDLE.
REQ-030 Completion pulse (1 cycle, combinational from bus response): owner IFU -> ifu_rvalid_o; LSU read -> lsu_rvalid_o; LSU write -> lsu_wready_o; rdata forwarded from bus_rdata_i; err=0.
REQ-031 Non-owner completion outputs stay 0; rdata outputs 0 when their valid is 0.
REQ-032 Timeout counter increments each cycle in REQ/RESP; reaching TIMEOUT without completion forces completion pulse with err=1, rdata=0, state IDLE, bus_req_o=0 next cycle.
REQ-033 Response and timeout in same cycle: response wins, err=0.
REQ-034 Bus responses in IDLE, or in REQ without bus_gnt_i, are ignored.
REQ-035 Requester valid deasserting mid-transaction does not abort; transaction completes, pulse still emitted.
REQ-036 A requester valid still high in the IDLE cycle after its completion is a new request.
REQ-037 Arbitration never grants while state != IDLE; at most one outstanding transaction.

Reset
REQ-038 rst=1: state IDLE, owner IFU, last_owner IFU (LSU wins first conflict), counter 0, all outputs 0 next cycle.
REQ-039 Reset mid-transaction: no completion pulse emitted; late bus responses after reset ignored.

Verification
REQ-040 IFU alone, addr 0x8000_0000: bus_req_o cycle 2, gnt cycle 3, rvalid rdata 0x0000_0413 cycle 5 -> ifu_rvalid_o=1, ifu_rdata_o=0x0000_0413, err 0, same cycle.
REQ-041 IFU and LSU write both valid after reset -> LSU granted first (bus_we_o=1, wstrb 0xF), lsu_wready_o on bvalid; IFU granted next IDLE.
REQ-042 Both continuously valid for 4 transactions -> grants alternate LSU, IFU, LSU, IFU.
REQ-043 TIMEOUT=4, LSU read, no gnt -> lsu_rvalid_o=1, lsu_err_o=1, lsu_rdata_o=0 after 4 cycles in REQ; bus_req_o drops.
REQ-044 Response arrives on exact timeout cycle -> err 0, data forwarded.
REQ-045 rst asserted in RESP, bus_rvalid_i pulsed next cycle -> no ifu/lsu pulse; state IDLE.

Source files
------------

// File: rtl/ysyx_mem_arb.sv
// rtl/ysyx_mem_arb.sv - IFU/LSU memory bus arbiter with single outstanding transaction and timeout
`ifndef YSYX_W_WIDTH
`define YSYX_W_WIDTH 32
`endif

module ysyx_mem_arb #(
  parameter int BIT_W   = `YSYX_W_WIDTH,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ifu_arvalid_i,
  input  logic [BIT_W-1:0]   ifu_araddr_i,
  output logic               ifu_rvalid_o,
  output logic [BIT_W-1:0]   ifu_rdata_o,
  output logic               ifu_err_o,
  input  logic               lsu_avalid_i,
  input  logic               lsu_wen_i,
  input  logic [BIT_W-1:0]   lsu_addr_i,
  input  logic [BIT_W-1:0]   lsu_wdata_i,
  input  logic [BIT_W/8-1:0] lsu_wstrb_i,
  output logic               lsu_rvalid_o,
  output logic [BIT_W-1:0]   lsu_rdata_o,
  output logic               lsu_wready_o,
  output logic               lsu_err_o,
  output logic               bus_req_o,
  output logic               bus_we_o,
  output logic [BIT_W-1:0]   bus_addr_o,
  output logic [BIT_W-1:0]   bus_wdata_o,
  output logic [BIT_W/8-1:0] bus_wstrb_o,
  input  logic               bus_gnt_i,
  input  logic               bus_rvalid_i,
  input  logic [BIT_W-1:0]   bus_rdata_i,
  input  logic               bus_bvalid_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic       OWN_IFU  = 1'b0;
  localparam logic       OWN_LSU  = 1'b1;
  // Timeout fires in the TIMEOUT-th cycle spent outstanding (counter starts at 0).
  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       owner, last_owner;
  logic [9:0] cnt;
  logic       busy, grant, grant_lsu, rsp_hit, tmo, done;

  // Arbitration and completion decode; a response only counts once the bus has accepted
  always_comb begin
    busy      = (state == REQ) || (state == RESP);
    grant     = (state == IDLE) && (ifu_arvalid_i || lsu_avalid_i);
    grant_lsu = lsu_avalid_i && (!ifu_arvalid_i || (last_owner == OWN_IFU));
    rsp_hit   = ((state == RESP) || ((state == REQ) && bus_gnt_i)) &&
                (bus_we_o ? bus_bvalid_i : bus_rvalid_i);
    tmo       = busy && (cnt == CNT_LAST) && !rsp_hit;
    done      = (rsp_hit || tmo) && !rst;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = REQ;
      REQ:     if (done) state_nxt = IDLE;
               else if (bus_gnt_i) state_nxt = RESP;
      RESP:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch request fields and ownership at grant; age the outstanding transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      owner       <= OWN_IFU;
      last_owner  <= OWN_IFU;
      cnt         <= '0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_wstrb_o <= '0;
    end else if (grant) begin
      owner      <= grant_lsu ? OWN_LSU : OWN_IFU;
      last_owner <= grant_lsu ? OWN_LSU : OWN_IFU;
      cnt        <= '0;
      if (grant_lsu) begin
        bus_we_o    <= lsu_wen_i;
        bus_addr_o  <= lsu_addr_i;
        bus_wdata_o <= lsu_wdata_i;
        bus_wstrb_o <= lsu_wstrb_i;
      end else begin
        bus_we_o    <= 1'b0;
        bus_addr_o  <= ifu_araddr_i;
        bus_wdata_o <= '0;
        bus_wstrb_o <= '0;
      end
    end else if (busy) begin
      cnt <= cnt + 10'd1;
    end
  end

  // Outputs: request strobe from state, completion pulses routed to the owner
  always_comb begin
    bus_req_o    = (state == REQ);
    ifu_rvalid_o = done && (owner == OWN_IFU);
    lsu_rvalid_o = done && (owner == OWN_LSU) && !bus_we_o;
    lsu_wready_o = done && (owner == OWN_LSU) && bus_we_o;
    ifu_err_o    = ifu_rvalid_o && tmo;
    lsu_err_o    = (lsu_rvalid_o || lsu_wready_o) && tmo;
    ifu_rdata_o  = (ifu_rvalid_o && rsp_hit) ? bus_rdata_i : '0;
    lsu_rdata_o  = (lsu_rvalid_o && rsp_hit) ? bus_rdata_i : '0;
  end

endmodule

// File: tb/tb_ysyx_mem_arb.sv
// tb/tb_ysyx_mem_arb.sv - randomized and directed self-checking bench for ysyx_mem_arb
module tb_ysyx_mem_arb;
  localparam int W   = 32;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_arvalid_i, ifu_rvalid_o, ifu_err_o;
  logic [W-1:0]  ifu_araddr_i, ifu_rdata_o;
  logic          lsu_avalid_i, lsu_wen_i, lsu_rvalid_o, lsu_wready_o, lsu_err_o;
  logic [W-1:0]  lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
  logic [W/8-1:0] lsu_wstrb_i, bus_wstrb_o;
  logic          bus_req_o, bus_we_o, bus_gnt_i, bus_rvalid_i, bus_bvalid_i;
  logic [W-1:0]  bus_addr_o, bus_wdata_o, bus_rdata_i;

  ysyx_mem_arb #(.BIT_W(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .ifu_arvalid_i(ifu_arvalid_i), .ifu_araddr_i(ifu_araddr_i),
    .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o), .ifu_err_o(ifu_err_o),
    .lsu_avalid_i(lsu_avalid_i), .lsu_wen_i(lsu_wen_i), .lsu_addr_i(lsu_addr_i),
    .lsu_wdata_i(lsu_wdata_i), .lsu_wstrb_i(lsu_wstrb_i),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .lsu_wready_o(lsu_wready_o), .lsu_err_o(lsu_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_bvalid_i(bus_bvalid_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: the one transaction in flight, if any
  bit          m_active = 0, m_acc = 0, m_who = 0, m_we = 0, m_last = 0;
  logic [W-1:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_strb = '0;
  int          m_age = 0;
  bit          done_ifu, done_lsu;

  task automatic drv(input logic iv, input logic [W-1:0] ia, input logic lv, input logic lw,
                     input logic [W-1:0] la, input logic [W-1:0] ld, input logic [3:0] ls,
                     input logic g, input logic rv, input logic bv, input logic [W-1:0] rd);
    ifu_arvalid_i = iv; ifu_araddr_i = ia;
    lsu_avalid_i = lv; lsu_wen_i = lw; lsu_addr_i = la; lsu_wdata_i = ld; lsu_wstrb_i = ls;
    bus_gnt_i = g; bus_rvalid_i = rv; bus_bvalid_i = bv; bus_rdata_i = rd;
    #1;
  endtask

  task automatic tick();
    bit hit, tmo, dn, lw_win, req_any, gnt, lwen;
    logic [W-1:0] rdx, ia, la, ld;
    logic [3:0] ls;
    hit = 0; tmo = 0;
    if (m_active) begin
      hit = (m_we ? bus_bvalid_i : bus_rvalid_i) && (m_acc || bus_gnt_i);
      tmo = !hit && (m_age == TMO - 1);
    end
    dn = hit || tmo;
    rdx = hit ? bus_rdata_i : '0;
    done_ifu = dn && !m_who;
    done_lsu = dn && m_who;
    check("ifu_rvalid", 64'(ifu_rvalid_o), 64'(done_ifu));
    check("ifu_rdata",  64'(ifu_rdata_o),  64'(done_ifu ? rdx : '0));
    check("ifu_err",    64'(ifu_err_o),    64'(done_ifu && tmo));
    check("lsu_rvalid", 64'(lsu_rvalid_o), 64'(done_lsu && !m_we));
    check("lsu_wready", 64'(lsu_wready_o), 64'(done_lsu && m_we));
    check("lsu_rdata",  64'(lsu_rdata_o),  64'((done_lsu && !m_we) ? rdx : '0));
    check("lsu_err",    64'(lsu_err_o),    64'(done_lsu && tmo));
    check("bus_req",    64'(bus_req_o),    64'(m_active && !m_acc));
    if (m_active && !m_acc) begin
      check("bus_we",    64'(bus_we_o),    64'(m_we));
      check("bus_addr",  64'(bus_addr_o),  64'(m_addr));
      check("bus_wdata", 64'(bus_wdata_o), 64'(m_wdata));
      check("bus_wstrb", 64'(bus_wstrb_o), 64'(m_strb));
    end
    lw_win  = lsu_avalid_i && (!ifu_arvalid_i || !m_last);
    req_any = ifu_arvalid_i || lsu_avalid_i;
    gnt = bus_gnt_i; lwen = lsu_wen_i;
    ia = ifu_araddr_i; la = lsu_addr_i; ld = lsu_wdata_i; ls = lsu_wstrb_i;
    @(posedge clk); #1;
    if (m_active) begin
      if (dn) m_active = 0;
      else begin
        if (gnt) m_acc = 1;
        m_age++;
      end
    end else if (req_any) begin
      m_active = 1; m_acc = 0; m_age = 0;
      m_who = lw_win; m_last = lw_win;
      m_we    = lw_win ? lwen : 1'b0;
      m_addr  = lw_win ? la : ia;
      m_wdata = lw_win ? ld : '0;
      m_strb  = lw_win ? ls : 4'h0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_active = 0; m_acc = 0; m_last = 0; m_age = 0;
  endtask

  logic          iv = 0, lv = 0, lw = 0;
  logic [W-1:0]  ia = '0, la = '0, ld = '0;
  logic [3:0]    ls = '0;

  initial begin
    rst = 1'b1;
    drv(0, '0, 0, 0, '0, '0, 4'h0, 0, 0, 0, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_we",    64'(bus_we_o),    64'd0);
    check("rst_addr",  64'(bus_addr_o),  64'd0);
    check("rst_wdata", 64'(bus_wdata_o), 64'd0);
    check("rst_wstrb", 64'(bus_wstrb_o), 64'd0);
    tick();

    // IFU alone: grant, request, gnt, wait, read data
    drv(1, 32'h8000_0000, 0, 0, '0, '0, 4'h0, 0, 1, 0, 32'hDEAD);
    tick();
    drv(1, 32'h8000_0000, 0, 0, '0, '0, 4'h0, 0, 0, 0, '0);
    check("d40_req", 64'(bus_req_o), 64'd1);
    check("d40_addr", 64'(bus_addr_o), 64'h8000_0000);
    tick();
    drv(1, 32'h8000_0000, 0, 0, '0, '0, 4'h0, 1, 0, 0, '0);
    tick();
    drv(1, 32'h8000_0000, 0, 0, '0, '0, 4'h0, 0, 0, 0, '0);
    tick();
    drv(1, 32'h8000_0000, 0, 0, '0, '0, 4'h0, 0, 1, 0, 32'h0000_0413);
    check("d40_rvalid", 64'(ifu_rvalid_o), 64'd1);
    check("d40_rdata", 64'(ifu_rdata_o), 64'h413);
    check("d40_err", 64'(ifu_err_o), 64'd0);
    tick();
    drv(0, '0, 0, 0, '0, '0, 4'h0, 0, 0, 0, '0);
    tick();

    // Conflict after reset: LSU write first, then IFU
    do_reset();
    drv(1, 32'h8000_0100, 1, 1, 32'h2000, 32'h55AA, 4'hF, 0, 0, 0, '0);
    tick();
    drv(1, 32'h8000_0100, 1, 1, 32'h2000, 32'h55AA, 4'hF, 0, 0, 0, '0);
    check("d41_we", 64'(bus_we_o), 64'd1);
    check("d41_wstrb", 64'(bus_wstrb_o), 64'hF);
    tick();
    drv(1, 32'h8000_0100, 1, 1, 32'h2000, 32'h55AA, 4'hF, 1, 0, 1, '0);
    check("d41_wready", 64'(lsu_wready_o), 64'd1);
    tick();
    drv(1, 32'h8000_0100, 0, 0, '0, '0, 4'h0, 0, 0, 0, '0);
    tick();
    drv(1, 32'h8000_0100, 0, 0, '0, '0, 4'h0, 1, 1, 0, 32'h1234);
    check("d41_ifu_addr", 64'(bus_addr_o), 64'h8000_0100);
    check("d41_ifu_rv", 64'(ifu_rvalid_o), 64'd1);
    tick();

    // Continuous conflict alternates LSU, IFU, LSU, IFU
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drv(1, 32'h8000_0200, 1, 1, 32'h3000, 32'h1, 4'h3, 0, 0, 0, '0);
      tick();
      drv(1, 32'h8000_0200, 1, 1, 32'h3000, 32'h1, 4'h3, 1, 1, 1, 32'h77);
      check("d42_alt_we", 64'(bus_we_o), 64'((k % 2) == 0));
      tick();
    end
    drv(0, '0, 0, 0, '0, '0, 4'h0, 0, 0, 0, '0);
    tick();

    // LSU read timeout with no gnt; an ungranted rvalid is ignored
    drv(0, '0, 1, 0, 32'h100, '0, 4'h0, 0, 0, 0, '0);
    tick();
    for (int k = 0; k < TMO; k++) begin
      drv(0, '0, 1, 0, 32'h100, '0, 4'h0, 0, k == 1, 0, 32'hBAD);
      if (k == TMO - 1) begin
        check("d43_rvalid", 64'(lsu_rvalid_o), 64'd1);
        check("d43_err", 64'(lsu_err_o), 64'd1);
        check("d43_rdata", 64'(lsu_rdata_o), 64'd0);
      end
      tick();
    end
    drv(0, '0, 0, 0, '0, '0, 4'h0, 0, 0, 0, '0);
    check("d43_req_drop", 64'(bus_req_o), 64'd0);
    tick();

    // Response on the exact timeout cycle wins
    drv(0, '0, 1, 0, 32'h104, '0, 4'h0, 0, 0, 0, '0);
    tick();
    for (int k = 0; k < TMO; k++) begin
      drv(0, '0, 1, 0, 32'h104, '0, 4'h0, k == TMO - 1, k == TMO - 1, 0, 32'hCAFE);
      if (k == TMO - 1) begin
        check("d44_rvalid", 64'(lsu_rvalid_o), 64'd1);
        check("d44_err", 64'(lsu_err_o), 64'd0);
        check("d44_rdata", 64'(lsu_rdata_o), 64'hCAFE);
      end
      tick();
    end
    drv(0, '0, 0, 0, '0, '0, 4'h0, 0, 0, 0, '0);
    tick();

    // Reset while in RESP, late response afterwards
    drv(1, 32'h8000_0300, 0, 0, '0, '0, 4'h0, 0, 0, 0, '0);
    tick();
    drv(1, 32'h8000_0300, 0, 0, '0, '0, 4'h0, 1, 0, 0, '0);
    tick();
    drv(0, '0, 0, 0, '0, '0, 4'h0, 0, 1, 0, 32'h99);
    rst = 1'b1;
    #1 check("d45_rst_pulse", 64'(ifu_rvalid_o), 64'd0);
    do_reset();
    drv(0, '0, 0, 0, '0, '0, 4'h0, 0, 1, 0, 32'h99);
    check("d45_ifu", 64'(ifu_rvalid_o), 64'd0);
    check("d45_lsu", 64'(lsu_rvalid_o), 64'd0);
    tick();

    // Randomized traffic against the reference
    for (int n = 0; n < 3000; n++) begin
      if (!iv && ($urandom % 4) == 0) begin iv = 1; ia = $urandom; end
      if (!lv && ($urandom % 4) == 0) begin
        lv = 1; lw = 1'($urandom); la = $urandom; ld = $urandom; ls = 4'($urandom);
      end
      if (m_active && !m_who && ($urandom % 16) == 0) iv = 0;
      if (m_active && m_who && ($urandom % 16) == 0) lv = 0;
      if (($urandom % 250) == 0) do_reset();
      drv(iv, ia, lv, lw, la, ld, ls, ($urandom % 3) == 0, ($urandom % 3) == 0,
          ($urandom % 3) == 0, $urandom);
      tick();
      if (done_ifu) begin
        if (($urandom % 2) == 0) ia = $urandom; else iv = 0;
      end
      if (done_lsu) begin
        if (($urandom % 2) == 0) begin la = $urandom; lw = 1'($urandom); end else lv = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
